ppu_bg_line_fetch: RTL and testbench

Background scanline fetcher for the PPU. On a per-line start pulse it walks the scrolled tile map in tile RAM and fetches the matching 4-bpp pattern rows from pattern RAM. It then writes 256 resolved {palette, colour} pixel indices into the downstream background line buffer. It is the read-side consumer of port A of the VRAM tile and pattern RAMs; palette lookup happens downstream.

---
 rtl/ppu_pkg.sv | 40 ++++
 rtl/ppu_bg_line_fetch_if.sv | 31 +++
 rtl/ppu_bg_pixel_shifter.sv | 44 ++++
 rtl/ppu_bg_line_fetch.sv | 132 +++++++++++++
 tb/tb_ppu_bg_line_fetch.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the background line fetcher.
package ppu_pkg;

    // Tile map geometry and VRAM port-A address widths
    localparam int MAP_COLS  = 64;
    localparam int MAP_ROWS  = 64;
    localparam int TILRAM_AW = 12;
    localparam int PATRAM_AW = 13;

    // One output scanline and the number of tiles needed to cover it at any fine scroll
    localparam int LINE_W         = 256;
    localparam int TILES_PER_LINE = 33;

    // Tile RAM entry: [9:0] tile id, [13:10] palette, [14] hflip, [15] vflip
    typedef struct packed {
        logic       vflip;
        logic       hflip;
        logic [3:0] palette;
        logic [9:0] tile_id;
    } tile_entry_t;

    // Line-buffer pixel index
    typedef struct packed {
        logic [3:0] palette;
        logic [3:0] colour;
    } pix_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EMIT,
        ST_DONE
    } fetch_state_t;

    // Pixel x of a 4-bpp pattern row lives in bits [4x+3:4x]
    function automatic logic [3:0] pat_nibble(input logic [31:0] row, input logic [2:0] x);
        return row[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/ppu_bg_line_fetch_if.sv
// Control, VRAM read and line-buffer write signals of the background fetcher.
interface ppu_bg_line_fetch_if;
    import ppu_pkg::*;

    logic                 i_start;
    logic [7:0]           i_line;
    logic [8:0]           i_scroll_x;
    logic [8:0]           i_scroll_y;
    logic                 o_busy;
    logic                 o_done;
    logic [TILRAM_AW-1:0] o_tilram_addr;
    logic [15:0]          i_tilram_rddata;
    logic [PATRAM_AW-1:0] o_patram_addr;
    logic [31:0]          i_patram_rddata;
    logic                 o_lb_wren;
    logic [7:0]           o_lb_addr;
    logic [7:0]           o_lb_wrdata;

    // Fetcher side
    modport master (
        input  i_start, i_line, i_scroll_x, i_scroll_y, i_tilram_rddata, i_patram_rddata,
        output o_busy, o_done, o_tilram_addr, o_patram_addr, o_lb_wren, o_lb_addr, o_lb_wrdata
    );

    // Sequencer / VRAM / line-buffer side
    modport slave (
        output i_start, i_line, i_scroll_x, i_scroll_y, i_tilram_rddata, i_patram_rddata,
        input  o_busy, o_done, o_tilram_addr, o_patram_addr, o_lb_wren, o_lb_addr, o_lb_wrdata
    );

endinterface

// File: rtl/ppu_bg_pixel_shifter.sv
// Turns one 4-bpp pattern row into 8 consecutive {palette, colour} pixels.
module ppu_bg_pixel_shifter
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] row,
    input  logic [3:0]  palette,
    input  logic        hflip,
    output pix_idx_t    pix
);

    logic [31:0] row_reg;
    logic [3:0]  pal_reg;
    logic        hflip_reg;
    logic [2:0]  x_reg;
    pix_idx_t    pix_reg;

    // Load emits pixel 0 straight away; each enabled cycle after emits the next pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg   <= '0;
            pal_reg   <= '0;
            hflip_reg <= 1'b0;
            x_reg     <= '0;
            pix_reg   <= '0;
        end else if (load) begin
            row_reg   <= row;
            pal_reg   <= palette;
            hflip_reg <= hflip;
            x_reg     <= 3'd1;
            pix_reg   <= {palette, pat_nibble(row, hflip ? 3'd7 : 3'd0)};
        end else if (en) begin
            x_reg     <= x_reg + 3'd1;
            // 7 - x is the bitwise complement for a 3-bit index
            pix_reg   <= {pal_reg, pat_nibble(row_reg, hflip_reg ? ~x_reg : x_reg)};
        end
    end

    assign pix = pix_reg;

endmodule

// File: rtl/ppu_bg_line_fetch.sv
// Background scanline fetcher: scrolled tile-map walk, pattern fetch, line-buffer write.
module ppu_bg_line_fetch
    import ppu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    ppu_bg_line_fetch_if.master  bus
);

    fetch_state_t state_reg, state_next;

    // cnt_reg holds the cycle number relative to the accepted start (1 in the first busy cycle)
    logic [8:0]           cnt_reg;
    logic [2:0]           fine_x_reg;
    logic [5:0]           col0_reg;
    logic [5:0]           tile_row_reg;
    logic [2:0]           fine_y_reg;
    logic [3:0]           pal_reg;
    logic                 hflip_reg;
    logic [TILRAM_AW-1:0] tilram_addr_reg;
    logic [PATRAM_AW-1:0] patram_addr_reg;
    logic                 lb_wren_reg;
    logic [7:0]           lb_addr_reg;

    logic        busy, done, accept, last_wr, wr_next, tile_slot_ok, shift_load;
    logic [8:0]  y_sum;
    tile_entry_t entry;
    pix_idx_t    pix;

    assign y_sum        = {1'b0, bus.i_line} + bus.i_scroll_y;
    assign entry        = bus.i_tilram_rddata;
    assign accept       = (state_reg == ST_IDLE) && bus.i_start;
    assign last_wr      = lb_wren_reg && (lb_addr_reg == 8'(LINE_W - 1));
    // Only tiles 0..32 are ever fetched; later slots keep addresses where they are
    assign tile_slot_ok = (cnt_reg[8:3] <= 6'(TILES_PER_LINE - 1));
    assign shift_load   = busy && tile_slot_ok && (cnt_reg[2:0] == 3'd4);
    // Raw pixel (cnt - 4) is emitted next cycle; skip the first fine_x and stop after 256
    assign wr_next      = busy && !last_wr && (cnt_reg >= ({6'd0, fine_x_reg} + 9'd4));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE:  if (bus.i_start) state_next = ST_FETCH;
            ST_FETCH: begin
                busy = 1'b1;
                if (cnt_reg[2:0] == 3'd4) state_next = ST_EMIT;
            end
            ST_EMIT: begin
                busy = 1'b1;
                if (last_wr) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Fetch pipeline: tile k address at 8k, pattern address at 8k+2, row load at 8k+4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            fine_x_reg      <= '0;
            col0_reg        <= '0;
            tile_row_reg    <= '0;
            fine_y_reg      <= '0;
            pal_reg         <= '0;
            hflip_reg       <= 1'b0;
            tilram_addr_reg <= '0;
            patram_addr_reg <= '0;
        end else if (accept) begin
            cnt_reg         <= 9'd1;
            fine_x_reg      <= bus.i_scroll_x[2:0];
            col0_reg        <= bus.i_scroll_x[8:3];
            tile_row_reg    <= y_sum[8:3];
            fine_y_reg      <= y_sum[2:0];
            tilram_addr_reg <= {y_sum[8:3], bus.i_scroll_x[8:3]};
        end else if (busy) begin
            cnt_reg <= cnt_reg + 9'd1;
            if (tile_slot_ok && cnt_reg[2:0] == 3'd0)
                tilram_addr_reg <= {tile_row_reg, 6'(col0_reg + cnt_reg[8:3])};
            if (tile_slot_ok && cnt_reg[2:0] == 3'd2) begin
                // vflip mirrors the row: 7 - fine_y is the complement
                patram_addr_reg <= {entry.tile_id, fine_y_reg ^ {3{entry.vflip}}};
                pal_reg         <= entry.palette;
                hflip_reg       <= entry.hflip;
            end
        end
    end

    // Line-buffer write strobe and ascending address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_wren_reg <= 1'b0;
            lb_addr_reg <= '0;
        end else begin
            lb_wren_reg <= wr_next;
            if (wr_next)
                lb_addr_reg <= lb_wren_reg ? lb_addr_reg + 8'd1 : 8'd0;
        end
    end

    ppu_bg_pixel_shifter u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (shift_load),
        .en      (busy),
        .row     (bus.i_patram_rddata),
        .palette (pal_reg),
        .hflip   (hflip_reg),
        .pix     (pix)
    );

    assign bus.o_busy        = busy;
    assign bus.o_done        = done;
    assign bus.o_tilram_addr = tilram_addr_reg;
    assign bus.o_patram_addr = patram_addr_reg;
    assign bus.o_lb_wren     = lb_wren_reg;
    assign bus.o_lb_addr     = lb_addr_reg;
    assign bus.o_lb_wrdata   = pix;

endmodule

// File: tb/tb_ppu_bg_line_fetch.sv
// Bench for ppu_bg_line_fetch: VRAM models, scanline reference model, vector table and corner cases.
`timescale 1ns/1ps
module tb_ppu_bg_line_fetch;
    import ppu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ppu_bg_line_fetch_if bus();

    ppu_bg_line_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] tilram [0:4095];
    logic [31:0] patram [0:8191];

    // One-cycle-latency VRAM read ports
    always @(posedge clk) begin
        bus.i_tilram_rddata <= tilram[bus.o_tilram_addr];
        bus.i_patram_rddata <= patram[bus.o_patram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    int exp_pix [0:255];
    int exp_til [0:32];
    int exp_pat [0:32];
    int got_pix [0:255];
    int got_til [0:32];
    int got_pat [0:32];

    typedef struct {
        int line;
        int sx;
        int sy;
        int mode;
        int first;
        int done;
    } vec_t;

    vec_t vecs [0:4];

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // 0: test-plan map, 1/2: random, 3: hflip tile, 4: hflip+vflip tile
    task automatic fill_mem(input int mode);
        for (int i = 0; i < 4096; i++) tilram[i] = 16'($urandom);
        for (int i = 0; i < 8192; i++) patram[i] = $urandom;
        if (mode == 0) begin
            for (int k = 0; k < 64; k++) tilram[k] = {1'b0, 1'b0, 4'd3, 10'(k)};
            for (int t = 0; t < 1024; t++)
                for (int r = 0; r < 8; r++) begin
                    logic [31:0] w;
                    w = '0;
                    for (int x = 0; x < 8; x++) w[4*x +: 4] = 4'((t + x) % 16);
                    patram[t*8 + r] = w;
                end
        end else if (mode == 3 || mode == 4) begin
            for (int k = 0; k < 64; k++) tilram[k] = {(mode == 4), 1'b1, 4'd2, 10'd5};
            for (int r = 0; r < 8; r++) patram[40 + r] = (mode == 4) ? 32'hFFFF_FFFF : 32'h7654_3210;
            patram[45] = 32'h7654_3210;
        end
    endtask

    // Reference: the 256 pixels, tile addresses and pattern addresses of one line
    task automatic build_expect(input int line, input int sx, input int sy);
        int y, trow, fy, fx, col0;
        logic [15:0] e;
        logic [31:0] pat;
        y = (line + sy) % 512;
        trow = y / 8;
        fy = y % 8;
        fx = sx % 8;
        col0 = sx / 8;
        for (int k = 0; k <= 32; k++) begin
            exp_til[k] = trow * 64 + (col0 + k) % 64;
            e = tilram[exp_til[k]];
            exp_pat[k] = int'(e[9:0]) * 8 + (e[15] ? 7 - fy : fy);
        end
        for (int a = 0; a < 256; a++) begin
            int r, k, x, n;
            r = a + fx;
            k = r / 8;
            x = r % 8;
            e = tilram[exp_til[k]];
            pat = patram[exp_pat[k]];
            n = e[14] ? 7 - x : x;
            exp_pix[a] = int'(e[13:10]) * 16 + int'((pat >> (4 * n)) & 32'hF);
        end
    endtask

    // Runs one line; optional second start at mid_c, optional reset at rst_c (ends the run)
    task automatic run_line(input string tag, input int line, input int sx, input int sy,
                            input int mid_c, input int rst_c, input int exp_first, input int exp_done);
        int wr_n, done_n, done_c;
        build_expect(line, sx, sy);
        for (int k = 0; k <= 32; k++) begin got_til[k] = -1; got_pat[k] = -1; end
        for (int a = 0; a < 256; a++) got_pix[a] = -1;
        wr_n = 0;
        done_n = 0;
        done_c = -1;
        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_line     = 8'(line);
        bus.i_scroll_x = 9'(sx);
        bus.i_scroll_y = 9'(sy);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) bus.i_start = 1'b0;
            if (c == mid_c) begin
                bus.i_start    = 1'b1;
                bus.i_line     = 8'(line + 37);
                bus.i_scroll_x = 9'(sx + 13);
                bus.i_scroll_y = 9'(sy + 100);
            end
            if (c == mid_c + 1) bus.i_start = 1'b0;
            if (c == rst_c) begin
                rst_n = 1'b0;
                #1;
                check({tag, " rst busy"},   int'(bus.o_busy), 0);
                check({tag, " rst done"},   int'(bus.o_done), 0);
                check({tag, " rst wren"},   int'(bus.o_lb_wren), 0);
                check({tag, " rst tiladdr"}, int'(bus.o_tilram_addr), 0);
                check({tag, " rst pataddr"}, int'(bus.o_patram_addr), 0);
                check({tag, " rst lbaddr"}, int'(bus.o_lb_addr), 0);
                check({tag, " rst lbdata"}, int'(bus.o_lb_wrdata), 0);
                check({tag, " rst before writes end"}, int'(wr_n > 0 && wr_n < 256), 1);
                return;
            end
            if (c == 1)            check({tag, " busy rise"}, int'(bus.o_busy), 1);
            if (c == exp_done - 1) check({tag, " busy held"}, int'(bus.o_busy), 1);
            if (c == exp_done)     check({tag, " busy fall"}, int'(bus.o_busy), 0);
            if (c % 8 == 1 && c / 8 <= 32) got_til[c / 8] = int'(bus.o_tilram_addr);
            if (c % 8 == 3 && c / 8 <= 32) got_pat[c / 8] = int'(bus.o_patram_addr);
            if (bus.o_done) begin
                done_n++;
                done_c = c;
            end
            if (bus.o_lb_wren) begin
                n_cmp++;
                if (wr_n >= 256) begin
                    n_bad++;
                    $display("FAIL %s extra write: cycle %0d addr %0d, expected no write", tag, c, bus.o_lb_addr);
                end else begin
                    got_pix[wr_n] = int'(bus.o_lb_wrdata);
                    if (int'(bus.o_lb_addr) != wr_n || int'(bus.o_lb_wrdata) != exp_pix[wr_n] ||
                        c != exp_first + wr_n) begin
                        n_bad++;
                        $display("FAIL %s write %0d: got cycle %0d addr %0d data 0x%02h, expected cycle %0d addr %0d data 0x%02h",
                                 tag, wr_n, c, bus.o_lb_addr, bus.o_lb_wrdata, exp_first + wr_n, wr_n, exp_pix[wr_n]);
                    end
                end
                wr_n++;
            end
            if (c == exp_done + 2) break;
        end
        check({tag, " write count"}, wr_n, 256);
        check({tag, " done count"}, done_n, 1);
        check({tag, " done cycle"}, done_c, exp_done);
        for (int k = 0; k <= 32; k++) begin
            check($sformatf("%s tiladdr k%0d", tag, k), got_til[k], exp_til[k]);
            check($sformatf("%s pataddr k%0d", tag, k), got_pat[k], exp_pat[k]);
        end
    endtask

    initial begin
        int quiet;
        int line, sx, sy;
        vecs[0] = '{line: 0,   sx: 0,   sy: 0,   mode: 0, first: 5,  done: 261};
        vecs[1] = '{line: 0,   sx: 5,   sy: 0,   mode: 0, first: 10, done: 266};
        vecs[2] = '{line: 10,  sx: 504, sy: 508, mode: 2, first: 5,  done: 261};
        vecs[3] = '{line: 239, sx: 511, sy: 3,   mode: 1, first: 12, done: 268};
        vecs[4] = '{line: 100, sx: 130, sy: 400, mode: 1, first: 7,  done: 263};

        bus.i_start    = 1'b0;
        bus.i_line     = '0;
        bus.i_scroll_x = '0;
        bus.i_scroll_y = '0;
        fill_mem(1);
        repeat (3) @(negedge clk);
        check("reset busy",    int'(bus.o_busy), 0);
        check("reset done",    int'(bus.o_done), 0);
        check("reset wren",    int'(bus.o_lb_wren), 0);
        check("reset tiladdr", int'(bus.o_tilram_addr), 0);
        check("reset pataddr", int'(bus.o_patram_addr), 0);
        check("reset lbaddr",  int'(bus.o_lb_addr), 0);
        check("reset lbdata",  int'(bus.o_lb_wrdata), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table
        for (int i = 0; i < 5; i++) begin
            fill_mem(vecs[i].mode);
            run_line($sformatf("vec%0d", i), vecs[i].line, vecs[i].sx, vecs[i].sy,
                     -1, -1, vecs[i].first, vecs[i].done);
            if (vecs[i].mode == 0 && vecs[i].sx == 0)
                for (int a = 0; a < 256; a += 37)
                    check($sformatf("plan pix a%0d", a), got_pix[a], 8'h30 | ((a / 8 + a % 8) % 16));
            if (vecs[i].sx == 5)
                for (int a = 251; a < 256; a++)
                    check($sformatf("tile32 pix a%0d", a), got_pix[a], 8'h30 | (a - 251));
            if (vecs[i].sx == 504) begin
                check("wrap til k0", got_til[0], 12'h03F);
                check("wrap til k1", got_til[1], 12'h000);
                check("wrap til k2", got_til[2], 12'h001);
                check("wrap pat k1 row", got_pat[1] % 8, tilram[0][15] ? 1 : 6);
            end
        end

        // hflip: colours run 7..0 within each tile
        fill_mem(3);
        run_line("hflip", 0, 0, 0, -1, -1, 5, 261);
        for (int a = 0; a < 16; a++)
            check($sformatf("hflip pix a%0d", a), got_pix[a], 8'h20 | (7 - a % 8));

        // vflip with fine_y 2 addresses pattern row 5
        fill_mem(4);
        run_line("vflip", 2, 0, 0, -1, -1, 5, 261);
        check("vflip pataddr row5", got_pat[0], 5 * 8 + 5);
        for (int a = 0; a < 8; a++)
            check($sformatf("vflip pix a%0d", a), got_pix[a], 8'h20 | (7 - a));

        // A start while busy is ignored
        fill_mem(1);
        run_line("midstart", 20, 3, 77, 100, -1, 8, 264);

        // Reset mid-line, then silence until a fresh start
        fill_mem(1);
        run_line("midreset", 40, 0, 0, -1, 50, 5, 261);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.o_lb_wren || bus.o_busy) quiet++;
        end
        check("post-reset quiet", quiet, 0);
        run_line("after-reset", 40, 0, 0, -1, -1, 5, 261);

        // Random lines against the reference model
        for (int i = 0; i < 3; i++) begin
            line = int'($urandom_range(0, 239));
            sx   = int'($urandom_range(0, 511));
            sy   = int'($urandom_range(0, 511));
            fill_mem(1);
            run_line($sformatf("rand%0d", i), line, sx, sy, -1, -1, 5 + sx % 8, 261 + sx % 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
